// File: rtl/sp_pkg.sv
// Shared definitions for the strobed serial link: receiver state encoding and
// the default word width used by both ends of the link.
package sp_pkg;

  typedef enum logic [1:0] {
    SP_IDLE  = 2'd0,
    SP_SHIFT = 2'd1,
    SP_WAIT  = 2'd2
  } sp_state_t;

  localparam int SP_W_DEF = 8;

endpackage

// File: rtl/sp_rx.sv
// Serial-to-parallel receiver: W bits MSB first while e_in is high, word out with e_out pulse.
// Latency: e_out/data_out registered at the edge sampling the last bit; no backpressure.
// Optional SP_RX_FRAME_ERR_EN flags early e_in drops and excess bits on frame_err.
module sp_rx
  import sp_pkg::*;
#(
  parameter int W = SP_W_DEF
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         e_in,
  input  logic         data_in,
  output logic [W-1:0] data_out,
  output logic         e_out,
  output logic         busy,
  output logic         frame_err,
  output logic [7:0]   word_cnt
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  sp_state_t     state;
  sp_state_t     next_state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= SP_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SP_IDLE:  if (e_in) next_state = SP_SHIFT;
      SP_SHIFT: begin
        if (!e_in)             next_state = SP_IDLE;
        else if (cnt == LAST)  next_state = SP_WAIT;
      end
      SP_WAIT:  if (!e_in) next_state = SP_IDLE;
      default:  next_state = SP_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      shreg    <= '0;
      data_out <= '0;
      e_out    <= 1'b0;
      word_cnt <= 8'd0;
    end else begin
      e_out <= 1'b0;
      case (state)
        SP_IDLE: begin
          if (e_in) begin
            shreg <= W'(data_in);
            cnt   <= CW'(1);
          end
        end
        SP_SHIFT: begin
          if (!e_in) begin
            // partial word is dropped; data_out keeps the last good word
            cnt <= '0;
          end else if (cnt == LAST) begin
            data_out <= {shreg[W-2:0], data_in};
            e_out    <= 1'b1;
            word_cnt <= word_cnt + 8'd1;
            cnt      <= '0;
          end else begin
            shreg <= {shreg[W-2:0], data_in};
            cnt   <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SP_SHIFT);

`ifdef SP_RX_FRAME_ERR_EN
  logic excess_seen;

  // excess_seen limits the WAIT flag to one pulse per over-long strobe
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      frame_err   <= 1'b0;
      excess_seen <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == SP_SHIFT && !e_in) frame_err <= 1'b1;
      if (state == SP_WAIT) begin
        if (e_in && !excess_seen) begin
          frame_err   <= 1'b1;
          excess_seen <= 1'b1;
        end
      end else begin
        excess_seen <= 1'b0;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_sp_rx.sv
// Scoreboard bench for sp_rx (W=8): expected words queued at stimulus, checked on e_out.
module tb_sp_rx;
  import sp_pkg::*;

`ifdef SP_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic       e_in;
  logic       data_in;
  logic [7:0] data_out;
  logic       e_out;
  logic       busy;
  logic       frame_err;
  logic [7:0] word_cnt;

  int total = 0;
  int bad = 0;
  int fe_seen = 0;
  int fe_exp = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] exp_d[$];
  logic [7:0] exp_c[$];

  sp_rx #(.W(8)) dut (
    .CLK(CLK), .nRST(nRST), .e_in(e_in), .data_in(data_in),
    .data_out(data_out), .e_out(e_out), .busy(busy),
    .frame_err(frame_err), .word_cnt(word_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (e_out === 1'b1) begin
      if (exp_d.size() == 0) begin
        chk("spurious_e_out", 1, 0);
      end else begin
        chk("data_out", data_out, exp_d.pop_front());
        chk("word_cnt", word_cnt, exp_c.pop_front());
      end
    end
    if (frame_err === 1'b1) fe_seen++;
  end

  // e = rising edges since the first bit was presented
  task automatic edge_checks(input int e, input int n);
    if (e == 1 && n > 1) chk("busy_start", busy, 1);
    if (e == 8 && n >= 8) begin
      chk("e_out_at_8", e_out, 1);
      chk("busy_done", busy, 0);
    end
    if (n < 8 && e == n + 1) begin
      chk("early_drop_fe", frame_err, FE_EN);
      chk("early_drop_no_e_out", e_out, 0);
      chk("early_drop_busy", busy, 0);
    end
    if (n > 8 && e == 9)  chk("excess_fe", frame_err, FE_EN);
    if (n > 9 && e == 10) chk("excess_fe_once", frame_err, 0);
  endtask

  task automatic send(input logic [7:0] w, input int n, input int g);
    if (n >= 8) begin
      exp_cnt = exp_cnt + 8'd1;
      exp_d.push_back(w);
      exp_c.push_back(exp_cnt);
    end
    if (FE_EN && n != 8) fe_exp++;
    for (int i = 0; i < n + g; i++) begin
      @(negedge CLK);
      edge_checks(i, n);
      e_in = (i < n);
      data_in = (i < 8 && i < n) ? w[7-i] : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_e_out"}, e_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_word_cnt"}, word_cnt, 0);
  endtask

  initial begin
    logic [7:0] mid;
    nRST = 1'b0;
    e_in = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    nRST = 1'b1;
    @(negedge CLK);

    send(8'hA5, 8, 2);
    chk("a5_cnt", word_cnt, 1);
    chk("a5_fe", frame_err, 0);

    send(8'h3C, 8, 1);
    send(8'hFF, 8, 2);
    chk("b2b_cnt", word_cnt, 3);

    send(8'h96, 5, 2);
    chk("drop_hold", data_out, 8'hFF);
    chk("drop_cnt", word_cnt, 3);

    send(8'hC3, 10, 2);
    send(8'h5A, 8, 2);
    chk("after_excess", data_out, 8'h5A);

    // abort mid-word with an asynchronous reset after four bits
    mid = 8'hE7;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      e_in = 1'b1;
      data_in = mid[7-i];
    end
    @(negedge CLK);
    chk("mid_busy", busy, 1);
    nRST = 1'b0;
    e_in = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge CLK);
    nRST = 1'b1;
    exp_cnt = 8'd0;

    send(8'h81, 8, 2);
    chk("post_reset_cnt", word_cnt, 1);

    for (int k = 0; k < 255; k++) send(8'($urandom), 8, 1);
    @(negedge CLK);
    chk("wrap_cnt", word_cnt, 0);

    repeat (4) @(negedge CLK);
    chk("pending_words", exp_d.size(), 0);
    chk("fe_total", fe_seen, fe_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
